fsmc_sdram_bridge: RTL and testbench
====================================

Name: fsmc_sdram_bridge

Overview:
- Slave-side bridge between the STM32 FSMC asynchronous SRAM-style bus (NE1/NWE/NOE/NBL, 16-bit A/D) and the synchronous request/acknowledge port of the SDRAM controller.
- Synchronises the strobes, captures address and data, and issues one SDRAM word request per FSMC access.
- On reads, returns controller data onto fsmc_d.
- Sits inside system, directly upstream of the SDRAM controller.

Parameters:
- ADDR_W, 22: width of mem_addr; fsmc_a is zero-extended to this width.
- SETTLE, 2: synchronised-strobe-low cycles before address/data capture (range 1..15).
- TIMEOUT, 1023: maximum clk cycles to wait for mem_ack before abort (range 1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- fsmc_a  in  16  FSMC address
- fsmc_d  inout  16  FSMC data bus
- fsmc_ne1  in  1  chip enable, active low
- fsmc_nwe  in  1  write strobe, active low
- fsmc_noe  in  1  output enable, active low
- fsmc_nbl1  in  1  upper byte lane enable, active low
- fsmc_nbl0  in  1  lower byte lane enable, active low
- mem_req  out  1  request to SDRAM controller
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  write data
- mem_dm  out  2  byte mask, 1 = masked
- mem_ack  in  1  one-cycle acknowledge; read data is valid in the same cycle
- mem_rdata  in  16  read data
- busy  out  1  FSM not in IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_dm=0, busy=0, err=0, rd_valid=0, fsmc_d=Z, FSM=IDLE, synchronisers=1.
- Synchronisers: fsmc_ne1, fsmc_nwe and fsmc_noe each pass through a 2-flop synchroniser. fsmc_a, fsmc_d and nbl are sampled only at the capture cycle.
- wr_act = sync ne1=0 and sync nwe=0. rd_act = sync ne1=0 and sync noe=0. If both are active, write wins.
- IDLE:
  - A settle counter increments while wr_act or rd_act holds; it clears whenever neither holds.
  - When the counter reaches SETTLE: capture fsmc_a into mem_addr, fsmc_d into mem_wdata and byte lanes into mem_dm.
  - Same cycle: set mem_req=1, mem_we = wr_act, and go to REQ.
  - For reads, rd_valid clears at this point.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_dm stay stable until mem_ack.
  - On mem_ack: mem_req=0. If read, rd_reg <= mem_rdata and rd_valid=1. Go to RELEASE.
  - A timeout counter counts cycles in REQ. When it reaches TIMEOUT: mem_req=0, err=1, go to RELEASE.
  - A mem_ack arriving in the timeout cycle takes precedence; err stays 0.
- RELEASE: wait until sync ne1=1, then go to IDLE. This guarantees one request per FSMC access however long the strobe is held.
- Read drive: fsmc_d = rd_reg when raw fsmc_ne1=0, raw fsmc_noe=0 and rd_valid=1; otherwise Z. The output enable is taken from the raw pins so the bus releases immediately when the host deasserts.
- Read latency: capture happens 2+SETTLE cycles after the strobe falls, plus controller latency. The host FSMC DATAST must cover this.
- mem_ack while IDLE or RELEASE is ignored.
- Reset mid-access: outputs return to their reset values at once. A strobe still low after reset release starts a fresh access.
- busy = (FSM != IDLE). err is cleared only by reset.

Optional Feature:
- Macro: FSMC_BYTE_LANE_EN.
- Defined: mem_dm = {fsmc_nbl1, fsmc_nbl0}, captured with the address on writes; forced to 2'b00 on reads.
- Undefined: mem_dm is constant 2'b00, the nbl inputs are unused, and every access is a full 16-bit word.

Decomposition:
- Shared package (fsmc_pkg):
  - FSM state encoding: IDLE, REQ, RELEASE.
  - FSMC_DW=16 and FSMC_AW=16.
  - Default SETTLE and TIMEOUT values.
- Sub-module sync2: a 2-flop synchroniser with asynchronous active-low reset and reset value 1, instantiated three times.

Test Plan:
- Write at address 0x1000, data 0xAAAA, strobes low 50 us → exactly one mem_req with mem_we=1, mem_addr=0x1000, mem_wdata=0xAAAA. No second request while the strobe is held.
- Write 0x5555 to 0x1111, then read 0x1000 with the behavioural controller returning stored data → fsmc_d=0xAAAA while NOE is low, Z within one cycle after NOE rises.
- Controller never acks (TIMEOUT=16) → mem_req drops after 16 REQ cycles, err=1, busy=0 after NE1 rises. A following write still issues mem_req.
- Assert rst low while in REQ → mem_req=0, err=0 and fsmc_d=Z immediately, before the next clk edge.
- With FSMC_BYTE_LANE_EN defined: write with nbl1=1, nbl0=0 → mem_dm=2'b10. Without the macro, the same stimulus gives mem_dm=2'b00.
- NE1, NWE and NOE all low together → a single write request (mem_we=1) and fsmc_d is never driven.

Source files
------------

// File: rtl/fsmc_pkg.sv
// fsmc_pkg: shared state encoding, bus widths and default timing for the FSMC-to-SDRAM bridge.
package fsmc_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    localparam int FSMC_DW     = 16;
    localparam int FSMC_AW     = 16;
    localparam int DEF_SETTLE  = 2;
    localparam int DEF_TIMEOUT = 1023;
endpackage

// File: rtl/fsmc_sdram_bridge_sync2.sv
// sync2: two-flop synchroniser, resets to 1 so idle-high strobes read inactive.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {q, m} <= 2'b11;
        else      {q, m} <= {m, d};
endmodule

// File: rtl/fsmc_sdram_bridge.sv
// fsmc_sdram_bridge: FSMC async SRAM slave to SDRAM req/ack bridge, one request per access.
// Define FSMC_BYTE_LANE_EN to pass NBL byte lanes through to mem_dm on writes.
module fsmc_sdram_bridge
    import fsmc_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FSMC_AW-1:0] fsmc_a,
    inout  wire  [FSMC_DW-1:0] fsmc_d,
    input  logic               fsmc_ne1,
    input  logic               fsmc_nwe,
    input  logic               fsmc_noe,
    input  logic               fsmc_nbl1,
    input  logic               fsmc_nbl0,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [FSMC_DW-1:0] mem_wdata,
    output logic [1:0]         mem_dm,
    input  logic               mem_ack,
    input  logic [FSMC_DW-1:0] mem_rdata,
    output logic               busy,
    output logic               err
);
    state_t             state;
    logic               ne1_s, nwe_s, noe_s, wr_act, rd_act, rd_valid;
    logic [3:0]         settle_cnt;
    logic [15:0]        to_cnt;
    logic [FSMC_DW-1:0] rd_reg;

    sync2 u_ne1 (.clk(clk), .rst(rst), .d(fsmc_ne1), .q(ne1_s));
    sync2 u_nwe (.clk(clk), .rst(rst), .d(fsmc_nwe), .q(nwe_s));
    sync2 u_noe (.clk(clk), .rst(rst), .d(fsmc_noe), .q(noe_s));

    assign wr_act = !ne1_s && !nwe_s;
    assign rd_act = !ne1_s && !noe_s;
    assign busy   = state != IDLE;
    // Raw pins gate the driver so the bus frees as soon as the host lets go.
    assign fsmc_d = (!fsmc_ne1 && !fsmc_noe && rd_valid) ? rd_reg : {FSMC_DW{1'bz}};

`ifndef FSMC_BYTE_LANE_EN
    logic unused_nbl;
    assign unused_nbl = fsmc_nbl1 ^ fsmc_nbl0;
    assign mem_dm     = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef FSMC_BYTE_LANE_EN
            mem_dm     <= 2'b00;
`endif
            err        <= 1'b0;
            rd_valid   <= 1'b0;
            rd_reg     <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                IDLE:
                    if (!(wr_act || rd_act)) settle_cnt <= '0;
                    else if (settle_cnt == 4'(SETTLE - 1)) begin
                        mem_addr   <= ADDR_W'(fsmc_a);
                        mem_wdata  <= fsmc_d;
`ifdef FSMC_BYTE_LANE_EN
                        mem_dm     <= wr_act ? {fsmc_nbl1, fsmc_nbl0} : 2'b00;
`endif
                        mem_req    <= 1'b1;
                        mem_we     <= wr_act;
                        rd_valid   <= wr_act ? rd_valid : 1'b0;
                        settle_cnt <= '0;
                        to_cnt     <= '0;
                        state      <= REQ;
                    end else settle_cnt <= settle_cnt + 4'd1;
                REQ:
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rd_reg   <= mem_rdata;
                            rd_valid <= 1'b1;
                        end
                        state <= RELEASE;
                    end else if (to_cnt == 16'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= RELEASE;
                    end else to_cnt <= to_cnt + 16'd1;
                RELEASE:
                    if (ne1_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsmc_sdram_bridge.sv
// tb_fsmc_sdram_bridge: directed checks of the bridge against a one-cycle-ack behavioural controller.
module tb_fsmc_sdram_bridge;
    logic        clk = 1'b0, rst = 1'b0;
    logic [15:0] fsmc_a = '0, d_drv = '0;
    logic        d_oe = 1'b0;
    logic        fsmc_ne1 = 1'b1, fsmc_nwe = 1'b1, fsmc_noe = 1'b1, fsmc_nbl1 = 1'b0, fsmc_nbl0 = 1'b0;
    tri1  [15:0] fsmc_d;
    logic        mem_req, mem_we, mem_ack = 1'b0, busy, err, ack_en = 1'b1, req_q = 1'b0;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata = '0;
    logic [1:0]  mem_dm;
    logic [15:0] mem [0:65535];
    int          total = 0, bad = 0, reqs = 0, req_cycles = 0, r0;
    logic        last_we;
    logic [21:0] last_addr;
    logic [15:0] last_wdata, rd;
    logic [1:0]  last_dm;
    logic        ok;

    assign fsmc_d = d_oe ? d_drv : 16'hzzzz;

    fsmc_sdram_bridge #(.ADDR_W(22), .SETTLE(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .fsmc_a(fsmc_a), .fsmc_d(fsmc_d),
        .fsmc_ne1(fsmc_ne1), .fsmc_nwe(fsmc_nwe), .fsmc_noe(fsmc_noe),
        .fsmc_nbl1(fsmc_nbl1), .fsmc_nbl0(fsmc_nbl0),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_dm(mem_dm), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_ack <= mem_req && !mem_ack && ack_en;
        if (mem_req && !mem_ack && ack_en) begin
            mem_rdata <= mem[mem_addr[15:0]];
            if (mem_we) mem[mem_addr[15:0]] <= mem_wdata;
        end
        req_q <= mem_req;
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && !req_q) begin
            reqs       <= reqs + 1;
            last_we    <= mem_we;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
            last_dm    <= mem_dm;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fsmc_write(input logic [15:0] a, input logic [15:0] d, input int hold);
        fsmc_a = a; d_drv = d; d_oe = 1'b1; fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
        cycles(hold);
        fsmc_nwe = 1'b1; fsmc_ne1 = 1'b1; d_oe = 1'b0;
        cycles(6);
    endtask

    task automatic fsmc_read(input logic [15:0] a, input int hold, output logic [15:0] d);
        fsmc_a = a; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
        cycles(hold);
        d = fsmc_d;
        fsmc_noe = 1'b1;
        #1 check("rd_release", 32'(fsmc_d), 32'hFFFF);
        fsmc_ne1 = 1'b1;
        cycles(6);
    endtask

    initial begin
        mem[16'h3000] = 16'h0C0C;
        cycles(3);
        check("rst_req", 32'(mem_req), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_dm", 32'(mem_dm), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_d", 32'(fsmc_d), 32'hFFFF);
        rst = 1'b1;
        cycles(3);

        r0 = reqs;
        fsmc_a = 16'h1000; d_drv = 16'hAAAA; d_oe = 1'b1; fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
        cycles(5000);
        check("long_busy", 32'(busy), 1);
        fsmc_nwe = 1'b1; fsmc_ne1 = 1'b1; d_oe = 1'b0;
        cycles(6);
        check("long_nreq", 32'(reqs - r0), 1);
        check("long_we", 32'(last_we), 1);
        check("long_addr", 32'(last_addr), 32'h1000);
        check("long_wdata", 32'(last_wdata), 32'hAAAA);
        check("long_idle", 32'(busy), 0);

        fsmc_write(16'h1111, 16'h5555, 20);
        check("w2_addr", 32'(last_addr), 32'h1111);
        check("w2_wdata", 32'(last_wdata), 32'h5555);
        fsmc_read(16'h1000, 20, rd);
        check("rd1_data", 32'(rd), 32'hAAAA);
        check("rd1_we", 32'(last_we), 0);
        fsmc_read(16'h1111, 20, rd);
        check("rd2_data", 32'(rd), 32'h5555);

        ack_en = 1'b0; req_cycles = 0; r0 = reqs;
        fsmc_a = 16'h2000; d_drv = 16'h0F0F; d_oe = 1'b1; fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
        cycles(40);
        check("to_cycles", 32'(req_cycles), 16);
        check("to_req", 32'(mem_req), 0);
        check("to_err", 32'(err), 1);
        check("to_busy_held", 32'(busy), 1);
        fsmc_nwe = 1'b1; fsmc_ne1 = 1'b1; d_oe = 1'b0;
        cycles(6);
        check("to_busy_rel", 32'(busy), 0);
        ack_en = 1'b1;
        fsmc_write(16'h2002, 16'h1234, 20);
        check("to_next_req", 32'(reqs - r0), 2);
        check("to_next_addr", 32'(last_addr), 32'h2002);
        check("to_err_sticky", 32'(err), 1);

        ack_en = 1'b0;
        fsmc_a = 16'h3000; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("mid_in_req", 32'(mem_req), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_req", 32'(mem_req), 0);
        check("mid_err", 32'(err), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_d", 32'(fsmc_d), 32'hFFFF);
        @(negedge clk);
        r0 = reqs; ack_en = 1'b1; rst = 1'b1;
        cycles(20);
        check("mid_fresh_req", 32'(reqs - r0), 1);
        check("mid_fresh_d", 32'(fsmc_d), 32'h0C0C);
        fsmc_noe = 1'b1; fsmc_ne1 = 1'b1;
        cycles(6);

        fsmc_nbl1 = 1'b1; fsmc_nbl0 = 1'b0;
        fsmc_write(16'h4000, 16'hBEEF, 20);
        fsmc_nbl1 = 1'b0;
`ifdef FSMC_BYTE_LANE_EN
        check("dm_lanes", 32'(last_dm), 32'h2);
`else
        check("dm_lanes", 32'(last_dm), 32'h0);
`endif

        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        r0 = reqs; ok = 1'b1;
        fsmc_a = 16'h5000; fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0; fsmc_noe = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fsmc_d !== 16'hFFFF) ok = 1'b0;
        end
        check("both_undriven", 32'(ok), 1);
        fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1; fsmc_noe = 1'b1;
        cycles(6);
        check("both_nreq", 32'(reqs - r0), 1);
        check("both_we", 32'(last_we), 1);
        check("both_addr", 32'(last_addr), 32'h5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
